// File: rtl/gmm_sram_ctrl_pkg.sv
// rtl/gmm_sram_ctrl_pkg.sv - shared GMM SRAM controller types and defaults
package gmm_sram_ctrl_pkg;

    localparam int GMM_ADDR_W = 23;
    localparam int GMM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_TURN  = 2'd3
    } gmm_state_e;

    function automatic gmm_state_e access_state(input logic we);
        return we ? ST_WRITE : ST_READ;
    endfunction

endpackage

// File: rtl/gmm_req_fifo.sv
// rtl/gmm_req_fifo.sv - request queue, head visible combinationally on rdata_o
module gmm_req_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gmm_sram_ctrl.sv
// rtl/gmm_sram_ctrl.sv - in-order single-cycle async SRAM controller for GMM parameters
module gmm_sram_ctrl
    import gmm_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = GMM_ADDR_W,
    parameter int DATA_W     = GMM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);
    localparam int REQ_W = 1 + ADDR_W + DATA_W;

    gmm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [DATA_W-1:0] cur_wdata_q;
    logic              last_we_q;
    logic              have_dir_q;
    logic              rdy_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [REQ_W-1:0]  fifo_head;
    logic              head_we;
    logic              need_turn;

    assign fifo_push = req_valid && req_ready;
    assign head_we   = fifo_head[REQ_W-1];

    gmm_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({req_we, req_addr, req_wdata}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // have_dir_q is clear after reset so the very first access never pays a turnaround.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        need_turn = have_dir_q && (head_we != last_we_q);
        sram_ce_n = 1'b1;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        case (state_q)
            ST_TURN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    fifo_pop = 1'b1;
                    state_d  = access_state(head_we);
                end
            end
            default: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (need_turn) begin
                    state_d = ST_TURN;
                end else begin
                    fifo_pop = 1'b1;
                    state_d  = access_state(head_we);
                end
            end
        endcase
        if (state_q == ST_READ) begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
        end else if (state_q == ST_WRITE) begin
            sram_ce_n = 1'b0;
            sram_we_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
            last_we_q   <= 1'b0;
            have_dir_q  <= 1'b0;
            rdy_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            rsp_valid_q <= (state_q == ST_READ);
            if (state_q == ST_READ) rsp_data_q <= sram_data;
            if (fifo_pop) begin
                cur_addr_q  <= fifo_head[DATA_W +: ADDR_W];
                cur_wdata_q <= fifo_head[DATA_W-1:0];
                last_we_q   <= head_we;
                have_dir_q  <= 1'b1;
            end
        end
    end

    assign sram_data = (state_q == ST_WRITE) ? cur_wdata_q : {DATA_W{1'bz}};
    assign sram_addr = cur_addr_q;
    assign req_ready = rdy_q && !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_gmm_sram_ctrl.sv
// tb/tb_gmm_sram_ctrl.sv - scoreboard bench for gmm_sram_ctrl
module tb_gmm_sram_ctrl;

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [22:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, busy;
    logic [31:0] rsp_data;
    logic [22:0] sram_addr;
    wire  [31:0] sram_data;
    logic        sram_ce_n, sram_we_n, sram_oe_n;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int wr_seen = 0;
    int ov_cnt = 0;
    int bus_err = 0;
    int stall_cnt = 0;

    req_t pend[$];
    req_t acc_exp[$];
    logic [31:0] rsp_exp[$];
    int acc_cyc[$];
    int rsp_cyc[$];
    req_t mon_e;

    logic [31:0] sram_mem [256] = '{default: 32'h0};
    logic [31:0] model_rd;

    gmm_sram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_ce_n (sram_ce_n),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Undriven bus reads as all ones, so any stray drive is visible.
    for (genvar b = 0; b < 32; b++) begin : g_pu
        pullup (sram_data[b]);
    end

    always_comb model_rd = sram_mem[sram_addr[7:0]];
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? model_rd : 32'hzzzz_zzzz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[7:0]] <= sram_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!sram_we_n && !sram_oe_n) ov_cnt++;
            if (sram_ce_n && sram_data !== 32'hFFFF_FFFF) bus_err++;
            if (!sram_ce_n) begin
                acc_cyc.push_back(cyc);
                if (!sram_we_n) wr_seen++;
                if (acc_exp.size() == 0) begin
                    chk("unexpected_access", 1, 0);
                end else begin
                    mon_e = acc_exp.pop_front();
                    chk("acc_dir", {63'd0, !sram_we_n}, {63'd0, mon_e.we});
                    chk("acc_addr", {41'd0, sram_addr}, {41'd0, mon_e.addr});
                    if (mon_e.we) chk("acc_wdata", {32'd0, sram_data}, {32'd0, mon_e.data});
                end
            end
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                if (rsp_exp.size() == 0) chk("unexpected_rsp", 1, 0);
                else chk("rsp_data", {32'd0, rsp_data}, {32'd0, rsp_exp.pop_front()});
            end
        end
    end

    task automatic add(input logic we, input logic [22:0] addr, input logic [31:0] data,
                       input logic [31:0] exp);
        req_t r;
        r.we = we; r.addr = addr; r.data = data; r.exp = exp;
        pend.push_back(r);
    endtask

    task automatic do_abort();
        chk("queued_at_abort", acc_exp.size(), 3);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("abort_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
        chk("abort_bus_hiz", {32'd0, sram_data}, 64'hFFFF_FFFF);
        chk("abort_ready_busy_rsp", {req_ready, busy, rsp_valid}, 3'b000);
        acc_exp.delete();
        rsp_exp.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_abort_ready", req_ready, 1);
        chk("post_abort_busy", busy, 0);
    endtask

    // Holds req_valid high, advancing only on cycles where the DUT is ready.
    task automatic stream(input int abort_wr, output int t_first, output bit aborted);
        int  i = 0;
        int  guard = 0;
        bit  stall_seen = 0;
        t_first = -1;
        aborted = 0;
        while (i < pend.size()) begin
            @(negedge clk);
            #1;
            if (abort_wr > 0 && wr_seen == abort_wr && !sram_we_n) begin
                do_abort();
                aborted = 1;
                pend.delete();
                return;
            end
            if (guard++ > 200) begin
                chk("stream_timeout", 1, 0);
                break;
            end
            req_valid = 1'b1;
            req_we    = pend[i].we;
            req_addr  = pend[i].addr;
            req_wdata = pend[i].data;
            if (req_ready) begin
                if (i == 0) t_first = cyc + 1;
                acc_exp.push_back(pend[i]);
                if (!pend[i].we) rsp_exp.push_back(pend[i].exp);
                i++;
            end else if (!stall_seen) begin
                stall_seen = 1;
                stall_cnt++;
                chk("full_at_stall", acc_exp.size(), 4);
            end
        end
        @(negedge clk);
        #1 req_valid = 1'b0;
        pend.delete();
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || acc_exp.size() != 0 || rsp_exp.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", n < 100, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, rb, t0, s0, wbase;
        bit ab;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;

        @(negedge clk);
        chk("reset_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
        chk("reset_bus_hiz", {32'd0, sram_data}, 64'hFFFF_FFFF);
        chk("reset_outputs", {req_ready, busy, rsp_valid}, 3'b000);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", req_ready, 1);

        // Write then read back: one turnaround, data one cycle after the read access.
        add(1, 23'h000010, 32'hDEAD_BEEF, 32'h0);
        add(0, 23'h000010, 32'h0, 32'hDEAD_BEEF);
        b = acc_cyc.size(); rb = rsp_cyc.size();
        stream(0, t0, ab);
        drain();
        chk("t035_write_latency", acc_cyc[b], t0 + 1);
        chk("t035_read_after_turn", acc_cyc[b+1], t0 + 3);
        chk("t035_rsp_cycle", rsp_cyc[rb], t0 + 4);

        // Back-to-back writes then reads to 0..3; from IDLE after a read, writes turn first.
        for (int i = 0; i < 4; i++) add(1, 23'(i), 32'hA500_0000 | 32'(i), 32'h0);
        for (int i = 0; i < 4; i++) add(0, 23'(i), 32'h0, 32'hA500_0000 | 32'(i));
        b = acc_cyc.size(); rb = rsp_cyc.size();
        stream(0, t0, ab);
        drain();
        chk("t036_idle_turn", acc_cyc[b], t0 + 2);
        for (int k = 1; k < 8; k++)
            chk("t036_access_gap", acc_cyc[b+k] - acc_cyc[b+k-1], (k == 4) ? 2 : 1);
        for (int k = 1; k < 4; k++)
            chk("t036_rsp_gap", rsp_cyc[rb+k] - rsp_cyc[rb+k-1], 1);
        chk("t036_rsp_latency", rsp_cyc[rb], acc_cyc[b+4] + 1);

        // Alternating directions stall the path and fill the queue.
        s0 = stall_cnt;
        for (int k = 0; k < 4; k++) begin
            add(1, 23'h20 + 23'(k), 32'h1234_0000 + 32'(k), 32'h0);
            add(0, 23'h20 + 23'(k), 32'h0, 32'h1234_0000 + 32'(k));
        end
        b = acc_cyc.size();
        stream(0, t0, ab);
        drain();
        chk("t037_stalled", stall_cnt > s0, 1);
        chk("t037_access_count", acc_cyc.size() - b, 8);

        // Alternating at the top address: a turnaround between every pair.
        add(1, 23'h7FFFFF, 32'h0123_4567, 32'h0);
        add(0, 23'h7FFFFF, 32'h0, 32'h0123_4567);
        add(1, 23'h7FFFFF, 32'h89AB_CDEF, 32'h0);
        add(0, 23'h7FFFFF, 32'h0, 32'h89AB_CDEF);
        add(1, 23'h7FFFFF, 32'h5A5A_A5A5, 32'h0);
        add(0, 23'h7FFFFF, 32'h0, 32'h5A5A_A5A5);
        b = acc_cyc.size();
        stream(0, t0, ab);
        drain();
        for (int k = 1; k < 6; k++)
            chk("t038_turn_gap", acc_cyc[b+k] - acc_cyc[b+k-1], 2);
        chk("t038_we_oe_overlap", ov_cnt, 0);

        // Reset during the second write, with three requests behind it.
        wbase = wr_seen;
        for (int k = 0; k < 4; k++) begin
            add(1, 23'h40 + 23'(k), 32'hC0DE_0000 + 32'(k), 32'h0);
            add(0, 23'h40 + 23'(k), 32'h0, 32'hC0DE_0000 + 32'(k));
        end
        stream(wbase + 2, t0, ab);
        chk("t039_abort_reached", ab, 1);
        repeat (2) @(negedge clk);
        add(0, 23'h41, 32'h0, 32'h0);
        add(0, 23'h40, 32'h0, 32'hC0DE_0000);
        b = acc_cyc.size();
        stream(0, t0, ab);
        drain();
        chk("t039_first_read_latency", acc_cyc[b], t0 + 1);
        chk("t039_access_count", acc_cyc.size() - b, 2);

        chk("bus_driven_outside_access", bus_err, 0);
        chk("we_oe_overlap_total", ov_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
